// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Purpose : Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
//           LSB-first shifting, WIDTH cycles per addition.
// Revision: 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Full-adder cell fed from the operand LSBs and the carry flop.
  logic             s_d;
  logic             c_d;
  logic [WIDTH-1:0] shreg_d;

  assign s_d     = a_q[0] ^ b_q[0] ^ c_q;
  assign c_d     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign shreg_d = {s_d, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          shreg_q <= shreg_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          c_q     <= c_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            sum_q   <= shreg_d;
            cout_q  <= c_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status is a pure state decode, so inputs never reach outputs combinationally.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Purpose : Scoreboard bench for serial_adder_ctrl (WIDTH=8), directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int errors;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] held;
  logic           rst_seen;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Remember whether the last rising edge saw reset asserted.
  initial begin
    rst_seen = 1'b0;
    forever begin
      @(posedge clk);
      rst_seen = !rst_n;
    end
  end

  // Monitor: pops an expectation on every done pulse, otherwise checks the hold value.
  initial begin
    logic [WIDTH:0] e;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        held = '0;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'({cout, sum}), 32'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'({cout, sum}), 32'(e));
          held = e;
        end
      end else begin
        chk("hold", 32'({cout, sum}), 32'(held));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation, check done latency and busy span. When hold is set,
  // start stays high with decoy operands through ADD and DONE.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [8:0] exp, input bit hold);
    wait_idle();
    start = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    if (hold) begin
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b0;
    end else begin
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      cin = 1'b0;
    end
    chk("busy_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk);
      #1;
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_latency", 32'(done), (k == WIDTH) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    int cyc;
    int t_acc[3];
    logic prev_busy;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum", 32'({cout, sum}), 32'd0);
    repeat (2) @(posedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 9'h000, 1'b0);

    do_op(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("sum_hold_idle", 32'({cout, sum}), 32'h030);
    do_op(8'h01, 8'h02, 1'b0, 9'h003, 1'b0);

    // Abort with reset while cnt==4.
    wait_idle();
    start = 1'b1;
    a = 8'h33;
    b = 8'h44;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'({cout, sum}), 32'd0);
    repeat (12) @(posedge clk);
    do_op(8'h01, 8'h01, 1'b0, 9'h002, 1'b0);

    // Continuous start: acceptances every WIDTH+2 cycles.
    wait_idle();
    start = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    cin = 1'b0;
    acc = 0;
    cyc = 0;
    prev_busy = 1'b0;
    while (acc < 3 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !prev_busy) begin
        exp_q.push_back(9'h010);
        t_acc[acc] = cyc;
        acc++;
        if (acc == 3) start = 1'b0;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("accept_count", 32'(acc), 32'd3);
    if (acc == 3) begin
      chk("accept_period1", 32'(t_acc[1] - t_acc[0]), 32'd10);
      chk("accept_period2", 32'(t_acc[2] - t_acc[1]), 32'd10);
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
